// File: rtl/seq_code_lock_if.sv
// Digit-entry bus between the keypad front end and seq_code_lock.
// master drives digits and strobes; slave (the lock) returns status.
interface seq_code_lock_if #(
  parameter int DIGIT_W  = 4,
  parameter int N_DIGITS = 2,
  parameter int MAX_FAIL = 3
);
  localparam int POS_W = $clog2(N_DIGITS + 1);
  localparam int CNT_W = $clog2(MAX_FAIL + 1);

  logic [DIGIT_W-1:0] digit_in;
  logic               enter;
  logic               clear;
  logic [POS_W-1:0]   pos;
  logic               match;
  logic               fail;
  logic [CNT_W-1:0]   fail_cnt;
  logic               locked;
  logic [6:0]         hex_seg;

  modport master (
    output digit_in, enter, clear,
    input  pos, match, fail, fail_cnt, locked, hex_seg
  );

  modport slave (
    input  digit_in, enter, clear,
    output pos, match, fail, fail_cnt, locked, hex_seg
  );
endinterface

// File: rtl/seq_code_lock.sv
// Sequential code lock: N_DIGITS digits compared against CODE, failure count, timed lockout.
// Optional macro SEQ_CODE_LOCK_HEX_ECHO_EN echoes the last accepted digit on hex_seg.
module seq_code_lock #(
  parameter int                            DIGIT_W     = 4,
  parameter int                            N_DIGITS    = 2,
  parameter logic [N_DIGITS*DIGIT_W-1:0]   CODE        = 8'h43,
  parameter int                            MAX_FAIL    = 3,
  parameter int                            LOCK_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  seq_code_lock_if.slave bus
);
  localparam int POS_W = $clog2(N_DIGITS + 1);
  localparam int CNT_W = $clog2(MAX_FAIL + 1);
  localparam int TMR_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, LOCKOUT} state_t;

  state_t             state;
  logic [POS_W-1:0]   pos_q;
  logic               mis_q;
  logic               match_q;
  logic               fail_q;
  logic [CNT_W-1:0]   fail_cnt_q;
  logic               locked_q;
  logic [TMR_W-1:0]   timer_q;

  logic [DIGIT_W-1:0] exp_digit;
  logic               entering;
  logic               accept;
  logic               abort;
  logic               last;
  logic               miss;
  logic               to_lockout;

  // The first digit entered is the most significant one of CODE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    exp_digit = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (int'(pos_q) == N_DIGITS - 1 - i) exp_digit = CODE[i*DIGIT_W +: DIGIT_W];
    end
  end

  assign entering   = (state == IDLE) || (state == COLLECT);
  assign abort      = entering && bus.clear;
  assign accept     = entering && bus.enter && !bus.clear;
  assign last       = (pos_q == POS_W'(N_DIGITS - 1));
  assign miss       = mis_q || (bus.digit_in != exp_digit);
  assign to_lockout = (state == CHECK) && (fail_cnt_q == CNT_W'(MAX_FAIL));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pos_q      <= '0;
      mis_q      <= 1'b0;
      match_q    <= 1'b0;
      fail_q     <= 1'b0;
      fail_cnt_q <= '0;
      locked_q   <= 1'b0;
      timer_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      match_q <= 1'b0;
      fail_q  <= 1'b0;
      unique case (state)
        IDLE, COLLECT: begin
          if (abort) begin
            pos_q <= '0;
            mis_q <= 1'b0;
            state <= IDLE;
          end else if (accept) begin
            pos_q <= pos_q + POS_W'(1);
            if (last) begin
              // Verdict is registered here so it is visible during CHECK.
              match_q    <= !miss;
              fail_q     <= miss;
              fail_cnt_q <= miss ? fail_cnt_q + CNT_W'(1) : '0;
              mis_q      <= 1'b0;
              state      <= CHECK;
            end else begin
              mis_q <= miss;
              state <= COLLECT;
            end
          end
        end
        CHECK: begin
          pos_q <= '0;
          mis_q <= 1'b0;
          if (to_lockout) begin
            locked_q <= 1'b1;
            timer_q  <= TMR_W'(LOCK_CYCLES - 1);
            state    <= LOCKOUT;
          end else begin
            state <= IDLE;
          end
        end
        LOCKOUT: begin
          if (timer_q == '0) begin
            locked_q   <= 1'b0;
            fail_cnt_q <= '0;
            state      <= IDLE;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pos      = pos_q;
  assign bus.match    = match_q;
  assign bus.fail     = fail_q;
  assign bus.fail_cnt = fail_cnt_q;
  assign bus.locked   = locked_q;

`ifdef SEQ_CODE_LOCK_HEX_ECHO_EN
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [6:0] hex_q;

  // Active-low, bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    unique case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q <= SEG_BLANK;
    end else if (abort) begin
      hex_q <= SEG_BLANK;
    end else if (accept) begin
      hex_q <= last ? SEG_BLANK : seg7(4'(bus.digit_in));
    end else if (to_lockout) begin
      hex_q <= SEG_DASH;
    end else if (state == LOCKOUT && timer_q == '0) begin
      hex_q <= SEG_BLANK;
    end
  end

  assign bus.hex_seg = hex_q;
`else
  assign bus.hex_seg = 7'b1111111;
`endif
endmodule

// File: tb/tb_seq_code_lock.sv
// Directed bench for seq_code_lock with default parameters (code 4,3; 3 fails; 16-cycle lockout).
module tb_seq_code_lock;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_locked;

  always #5 clk = ~clk;

  seq_code_lock_if #(.DIGIT_W(4), .N_DIGITS(2), .MAX_FAIL(3)) bus ();

  seq_code_lock #(
    .DIGIT_W(4), .N_DIGITS(2), .CODE(8'h43), .MAX_FAIL(3), .LOCK_CYCLES(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Echo value when the hex feature is built in, blank otherwise.
  task automatic check_hex(input string tag, input logic [6:0] echo);
`ifdef SEQ_CODE_LOCK_HEX_ECHO_EN
    check(tag, 32'(bus.hex_seg), 32'(echo));
`else
    check(tag, 32'(bus.hex_seg), 32'h7F);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    bus.digit_in = d;
    bus.enter    = 1'b1;
    step();
    bus.enter    = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pos"},    32'(bus.pos), 0);
    check({tag, "_match"},  32'(bus.match), 0);
    check({tag, "_fail"},   32'(bus.fail), 0);
    check({tag, "_cnt"},    32'(bus.fail_cnt), 0);
    check({tag, "_locked"}, 32'(bus.locked), 0);
    check_hex({tag, "_hex"}, 7'b1111111);
  endtask

  task automatic enter_ok(input string tag);
    press(4'h4);
    press(4'h3);
    check({tag, "_match"}, 32'(bus.match), 1);
    check({tag, "_fail"},  32'(bus.fail), 0);
    check({tag, "_cnt"},   32'(bus.fail_cnt), 0);
    step();
    check({tag, "_match_drop"}, 32'(bus.match), 0);
  endtask

  task automatic enter_bad(input string tag, input int exp_cnt);
    press(4'h1);
    press(4'h1);
    check({tag, "_fail"},  32'(bus.fail), 1);
    check({tag, "_match"}, 32'(bus.match), 0);
    check({tag, "_cnt"},   32'(bus.fail_cnt), 32'(exp_cnt));
  endtask

  initial begin
    bus.digit_in = '0;
    bus.enter    = 1'b0;
    bus.clear    = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_reset_state("rst");

    // Correct code with pos progression
    press(4'h4);
    check("t1_pos1", 32'(bus.pos), 1);
    check("t1_nomatch", 32'(bus.match), 0);
    check_hex("t1_hex4", 7'b0011001);
    press(4'h3);
    check("t1_pos2", 32'(bus.pos), 2);
    check("t1_match", 32'(bus.match), 1);
    check("t1_fail", 32'(bus.fail), 0);
    check("t1_cnt", 32'(bus.fail_cnt), 0);
    check_hex("t1_hex_check", 7'b1111111);
    step();
    check("t1_match_drop", 32'(bus.match), 0);
    check("t1_pos0", 32'(bus.pos), 0);

    // Wrong second digit, then recovery
    press(4'h4);
    press(4'h5);
    check("t2_fail", 32'(bus.fail), 1);
    check("t2_match", 32'(bus.match), 0);
    check("t2_cnt", 32'(bus.fail_cnt), 1);
    step();
    check("t2_fail_drop", 32'(bus.fail), 0);
    check("t2_pos0", 32'(bus.pos), 0);
    enter_ok("t2_ok");

    // Three failures trigger lockout
    enter_bad("t3_bad1", 1);
    step();
    enter_bad("t3_bad2", 2);
    step();
    enter_bad("t3_bad3", 3);
    check("t3_not_yet_locked", 32'(bus.locked), 0);
    step();
    check("t3_locked", 32'(bus.locked), 1);
    check_hex("t3_dash", 7'b0111111);
    n_locked = 1;
    bus.digit_in = 4'h4;
    bus.enter    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!bus.locked) break;
      n_locked++;
      check("t3_lock_pos", 32'(bus.pos), 0);
      check("t3_lock_pulse", 32'({bus.match, bus.fail}), 0);
      check("t3_lock_cnt", 32'(bus.fail_cnt), 3);
    end
    bus.enter = 1'b0;
    check("t3_lock_len", 32'(n_locked), 16);
    check("t3_cnt_clr", 32'(bus.fail_cnt), 0);
    check("t3_pos_after", 32'(bus.pos), 0);
    check_hex("t3_hex_after", 7'b1111111);
    enter_ok("t3_ok");

    // Clear wins over simultaneous enter
    press(4'h4);
    bus.digit_in = 4'h3;
    bus.enter    = 1'b1;
    bus.clear    = 1'b1;
    step();
    bus.enter = 1'b0;
    bus.clear = 1'b0;
    check("t4_pos0", 32'(bus.pos), 0);
    check("t4_pulse", 32'({bus.match, bus.fail}), 0);
    check_hex("t4_hex_blank", 7'b1111111);
    step();
    check("t4_pulse2", 32'({bus.match, bus.fail}), 0);
    enter_ok("t4_ok");

    // Sticky mismatch: wrong first digit, right second
    press(4'h5);
    press(4'h3);
    check("t5_fail", 32'(bus.fail), 1);
    check("t5_cnt", 32'(bus.fail_cnt), 1);
    step();

    // Reset mid-entry
    press(4'h4);
    check("t6_pos1", 32'(bus.pos), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("t6_rst");
    enter_ok("t6_ok");

    // Reset mid-lockout
    enter_bad("t7_bad1", 1);
    step();
    enter_bad("t7_bad2", 2);
    step();
    enter_bad("t7_bad3", 3);
    step();
    step();
    step();
    check("t7_locked", 32'(bus.locked), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("t7_rst");
    enter_ok("t7_ok");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_code_lock.md
Name: seq_code_lock

Overview:
- Parametrised sequential successor to the switch-digit matcher on the DE1-SoC top level.
- Accepts a code of N_DIGITS digits, entered one per strobe (switch nibble plus a KEY-derived pulse), and compares the sequence against a compile-time CODE.
- Reports success or failure, counts consecutive failures, and enforces a timed lockout.
- Instantiated under DE1_SoC: digit_in from SW[3:0], enter/clear from edge-detected KEYs, outputs to LEDR.

Parameters:
- DIGIT_W, 4: bits per digit.
- N_DIGITS, 2: digits per code, must be >= 1.
- CODE, 8'h43: packed code, width N_DIGITS*DIGIT_W. The most significant digit is entered first (default sequence: 4 then 3).
- MAX_FAIL, 3: consecutive failures that trigger lockout, must be >= 1.
- LOCK_CYCLES, 16: lockout duration in clk cycles, must be >= 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- digit_in  in  DIGIT_W  digit value, sampled only when enter=1.
- enter  in  1  single-cycle strobe that accepts digit_in; already synchronised and edge-detected by the caller.
- clear  in  1  single-cycle strobe that aborts the current entry.
- pos  out  $clog2(N_DIGITS+1)  number of digits accepted so far.
- match  out  1  one-cycle pulse: code correct.
- fail  out  1  one-cycle pulse: code wrong.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failure count.
- locked  out  1  high during lockout.
- hex_seg  out  7  active-low 7-seg; see Optional Feature.

Behaviour:
- Reset (synchronous, clk edge with reset=1): state=IDLE, pos=0, mismatch flag=0, match=0, fail=0, fail_cnt=0, locked=0, lock timer=0, hex_seg=7'b1111111. Reset overrides every other input and applies in any state, including mid-entry and mid-lockout.
- States: IDLE, COLLECT, CHECK, LOCKOUT.
- IDLE: enter → store compare of digit_in against CODE digit [N_DIGITS-1-pos], pos=1, go to COLLECT. If N_DIGITS=1, go straight to CHECK.
- COLLECT: each enter performs compare, ORs any mismatch into the sticky flag, and increments pos. The enter that makes pos=N_DIGITS moves to CHECK.
- CHECK (exactly one cycle): outputs are registered and visible in this cycle, i.e. the cycle after the final enter is sampled.
  - If the flag is clear: match=1, fail_cnt=0.
  - Otherwise: fail=1 and fail_cnt increments. If the new fail_cnt equals MAX_FAIL, the next state is LOCKOUT; else IDLE.
  - In both cases pos=0 and the flag is cleared.
  - enter and clear are ignored in CHECK.
- LOCKOUT: locked=1, timer counts LOCK_CYCLES cycles. enter and clear are ignored. On expiry: locked=0, fail_cnt=0, state=IDLE.
  - locked rises the cycle after CHECK and stays high for exactly LOCK_CYCLES cycles.
- clear (IDLE/COLLECT): pos=0, flag=0, state=IDLE. fail_cnt is unchanged.
- clear and enter in the same cycle: clear wins and the digit is discarded.
- Comparison is on raw DIGIT_W bits; no BCD validity check. Non-BCD values simply mismatch unless CODE contains them.
- match and fail are never high in the same cycle. Neither is high outside CHECK.
- fail_cnt saturates at MAX_FAIL; it cannot wrap because LOCKOUT is entered on reaching it.

Optional Feature:
- Macro: SEQ_CODE_LOCK_HEX_ECHO_EN.
- Defined:
  - hex_seg shows the last accepted digit_in as an active-low 7-seg pattern (0-F), registered, updating the cycle after each accepted enter.
  - It blanks (7'b1111111) on reset, on clear, and on entry to CHECK.
  - During LOCKOUT it shows a dash (7'b0111111).
- Not defined: hex_seg is tied to 7'b1111111 and no decoder logic is compiled.

Test Plan:
- Defaults; enter 4, then enter 3 → pos goes 1 then 2; match=1 for one cycle immediately after the second enter; fail=0; fail_cnt=0.
- Enter 4 then 5 → fail pulse; fail_cnt=1; pos=0. Then enter 4, 3 → match pulse; fail_cnt=0.
- Three wrong codes (1,1) → fail_cnt reaches 3; locked=1 for exactly 16 cycles; enters during lockout cause no pos change and no pulses. After expiry fail_cnt=0, and 4,3 → match.
- Enter 4, then clear and enter(3) in the same cycle → pos=0, no pulse. Then enter 4, 3 → match.
- Reset asserted mid-entry (pos=1) and mid-lockout → next cycle all outputs are at reset values; a subsequent 4,3 → match.
- With SEQ_CODE_LOCK_HEX_ECHO_EN defined: enter 4 → hex_seg=7'b0011001; during lockout hex_seg=7'b0111111. Without the macro, hex_seg stays 7'b1111111 throughout.
